// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, byte handshake and status out.
// The master modport is the receiver; the slave modport is the line driver/consumer.
interface uart_rx_if;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx, rx_ready,
    output rx_byte, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    output rx, rx_ready,
    input  rx_byte, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register with
// valid/ready handshake, and single-cycle frame-error / overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_meta_q, rx_s_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q & ~bus.rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = FULL_LOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            // Leave mid-stop so a back-to-back start edge is not missed.
            state_d = IDLE;
            if (!rx_valid_q || bus.rx_ready) begin
              rx_byte_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit: directed scenarios plus random frames
// compared against an expected-byte queue built from what was transmitted.
module tb_uart_rx;

  localparam int BIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  int         v_run = 0;
  int         v_width = 0;
  logic       v_prev = 1'b0;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Observer: counts pulses, records handshakes and valid pulse widths.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.frame_err) fe_cnt++;
      if (u_if.overrun) ov_cnt++;
      if (u_if.frame_err && u_if.overrun) both_cnt++;
      if (u_if.rx_valid && u_if.rx_ready) acc_q.push_back(u_if.rx_byte);
      if (u_if.rx_valid && !v_prev) rise_cyc = cyc;
      if (u_if.rx_valid) v_run++;
      else if (v_prev) begin
        v_width = v_run;
        v_run   = 0;
      end
      v_prev = u_if.rx_valid;
    end else begin
      v_prev = 1'b0;
      v_run  = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves rx at the stop-bit level; callers restore idle after a bad stop.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    u_if.rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      tick(BIT);
    end
    u_if.rx = stop;
    tick(BIT);
    $display("frame sent byte=%02h stop=%0d", b, stop);
  endtask

  initial begin
    int fe0, ov0, lat, gap, hold;
    logic [7:0] b;
    logic bad;

    u_if.rx       = 1'b1;
    u_if.rx_ready = 1'b0;
    rst           = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check_eq("rst_byte", {24'd0, u_if.rx_byte}, 32'h00);
    check_eq("rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    check_eq("rst_ovr", {31'd0, u_if.overrun}, 32'd0);
    check_eq("rst_busy", {31'd0, u_if.busy}, 32'd0);
    @(posedge clk);
    #1;
    tick(5);

    // Single byte, consumer always ready.
    u_if.rx_ready = 1'b1;
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    tick(5);
    lat = rise_cyc - start_cyc;
    $display("A5 latency=%0d", lat);
    check_eq("a5_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check_eq("a5_byte", {24'd0, acc_q[0]}, 32'hA5);
    check_eq("a5_latency_window", {31'd0, (lat >= 90 && lat <= 100)}, 32'd1);
    check_eq("a5_valid_width", v_width, 1);
    check_eq("a5_ferr", fe_cnt - fe0, 0);
    check_eq("a5_ovr", ov_cnt - ov0, 0);

    // Back-to-back with consumer stalled: second byte overruns.
    u_if.rx_ready = 1'b0;
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(5);
    check_eq("ovr_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check_eq("ovr_byte", {24'd0, u_if.rx_byte}, 32'h3C);
    check_eq("ovr_pulses", ov_cnt - ov0, 1);
    check_eq("ovr_ferr", fe_cnt - fe0, 0);
    u_if.rx_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check_eq("ovr_drop_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check_eq("ovr_accepted", acc_q.size(), 1);
    if (acc_q.size() > 0) check_eq("ovr_acc_byte", {24'd0, acc_q[0]}, 32'h3C);
    @(posedge clk);
    #1;

    // Framing error followed by a long break.
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b0);
    tick(30);
    check_eq("brk_ferr", fe_cnt - fe0, 1);
    check_eq("brk_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check_eq("brk_busy_low_line", {31'd0, u_if.busy}, 32'd1);
    u_if.rx = 1'b1;
    tick(2);
    @(negedge clk);
    check_eq("brk_busy_2clk", {31'd0, u_if.busy}, 32'd1);
    @(negedge clk);
    check_eq("brk_busy_3clk", {31'd0, u_if.busy}, 32'd0);
    @(posedge clk);
    #1;
    tick(3);
    send_frame(8'h12, 1'b1);
    tick(5);
    check_eq("brk_next_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check_eq("brk_next_byte", {24'd0, acc_q[0]}, 32'h12);
    check_eq("brk_no_ovr", ov_cnt - ov0, 0);

    // Glitch shorter than half a bit.
    acc_q.delete();
    fe0 = fe_cnt;
    u_if.rx = 1'b0;
    tick(3);
    u_if.rx = 1'b1;
    tick(30);
    check_eq("glitch_none", acc_q.size(), 0);
    check_eq("glitch_ferr", fe_cnt - fe0, 0);
    check_eq("glitch_busy", {31'd0, u_if.busy}, 32'd0);

    // Reset mid-frame with a byte pending.
    u_if.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    tick(5);
    check_eq("pend_valid", {31'd0, u_if.rx_valid}, 32'd1);
    fe0 = fe_cnt; ov0 = ov_cnt;
    u_if.rx = 1'b0;
    tick(BIT);
    u_if.rx = 1'b1;
    tick(4 * BIT + 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    check_eq("mid_rst_byte", {24'd0, u_if.rx_byte}, 32'h00);
    check_eq("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    check_eq("mid_rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    check_eq("mid_rst_ovr", {31'd0, u_if.overrun}, 32'd0);
    @(posedge clk);
    #1;
    tick(60);
    check_eq("mid_rst_no_pulse", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check_eq("mid_rst_no_valid", {31'd0, u_if.rx_valid}, 32'd0);
    acc_q.delete();
    u_if.rx_ready = 1'b1;
    send_frame(8'h81, 1'b1);
    tick(5);
    check_eq("post_rst_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check_eq("post_rst_byte", {24'd0, acc_q[0]}, 32'h81);

    // Consumer accepts in the very cycle the next byte completes.
    u_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    tick(3);
    acc_q.delete();
    ov0 = ov_cnt;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        tick(97);
        u_if.rx_ready = 1'b1;
        tick(1);
        u_if.rx_ready = 1'b0;
      end
    join
    tick(3);
    check_eq("same_cyc_valid", {31'd0, u_if.rx_valid}, 32'd1);
    check_eq("same_cyc_byte", {24'd0, u_if.rx_byte}, 32'h7E);
    check_eq("same_cyc_ovr", ov_cnt - ov0, 0);
    check_eq("same_cyc_acc", acc_q.size(), 1);
    if (acc_q.size() > 0) check_eq("same_cyc_acc_byte", {24'd0, acc_q[0]}, 32'h11);
    u_if.rx_ready = 1'b1;
    tick(3);

    // Random frames: good ones must arrive in order, bad stops counted.
    acc_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    hold = 0;
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      if (bad) begin
        send_frame(b, 1'b0);
        tick($urandom_range(3, 20));
        u_if.rx = 1'b1;
        gap = $urandom_range(2, 12);
        hold++;
      end else begin
        send_frame(b, 1'b1);
        exp_q.push_back(b);
        gap = $urandom_range(0, 12);
      end
      tick(gap);
    end
    tick(20);
    check_eq("rnd_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      check_eq($sformatf("rnd_byte%0d", i), {24'd0, acc_q[i]}, {24'd0, exp_q[i]});
    check_eq("rnd_ferr", fe_cnt - fe0, hold);
    check_eq("rnd_ovr", ov_cnt - ov0, 0);
    check_eq("never_both_pulses", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer divide), HALF_DIV = BAUD_DIV/2.
REQ-003 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-006 rx_byte  output  8  last accepted data byte, stable while rx_valid=1.
REQ-007 rx_valid  output  1  rx_byte holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts rx_byte when rx_valid & rx_ready.
REQ-009 frame_err  output  1  single-cycle pulse, stop bit sampled low.
REQ-010 overrun  output  1  single-cycle pulse, completed byte dropped because previous byte unconsumed.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (reset value 1) before use; rx_s denotes the synchronized value.
REQ-013 States SHALL be IDLE, START, DATA, STOP, BREAK; baud counter width SHALL hold BAUD_DIV-1.
REQ-014 IDLE: rx_s=0 -> START, counter <= HALF_DIV-1.
REQ-015 Counter SHALL decrement each cycle in START/DATA/STOP; sample taken on the cycle counter==0.
REQ-016 START sample: rx_s=1 -> IDLE (false start, no pulse, no output change); rx_s=0 -> DATA, counter <= BAUD_DIV-1, bit index <= 0.
REQ-017 DATA sample: shift rx_s into MSB of 8-bit shift register (shift right), bit index +1, counter <= BAUD_DIV-1; after 8th sample -> STOP.
REQ-018 STOP sample, rx_s=1: -> IDLE same cycle; byte completes.
REQ-019 Byte completion with rx_valid=0, or rx_valid=1 and rx_ready=1: rx_byte <= shift register, rx_valid <= 1 next cycle; no overrun.
REQ-020 Byte completion with rx_valid=1 and rx_ready=0: rx_byte and rx_valid unchanged, overrun pulses 1 cycle.
REQ-021 STOP sample, rx_s=0: frame_err pulses 1 cycle, byte discarded, -> BREAK.
REQ-022 BREAK: remain until rx_s=1, then -> IDLE; no start detection while in BREAK.
REQ-023 rx_valid SHALL clear the cycle after rx_valid & rx_ready unless REQ-019 loads a new byte in the same cycle (new byte wins, rx_valid stays 1).
REQ-024 Receiver SHALL return to IDLE half a bit into the stop bit, allowing back-to-back frames with no idle gap.
REQ-025 Frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-026 rst=1 on a clock edge SHALL force: state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, rx_byte 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no pulses; the partial byte is never presented; after release, the next falling edge on rx_s starts a new frame.

Verification (CLK_FREQ=1_000_000, BAUD=100_000: BAUD_DIV=10, HALF_DIV=5)
REQ-028 Send 0xA5 as 8N1 (10 clk/bit), rx_ready=1 -> rx_valid pulses 1 cycle with rx_byte=0xA5 about 95 clks after start edge (sync latency included); frame_err=0, overrun=0.
REQ-029 Send 0x3C then 0xC3 back-to-back, rx_ready=0 -> 0x3C held with rx_valid=1, overrun pulses once at second stop sample, rx_byte remains 0x3C; raise rx_ready -> rx_valid drops next cycle.
REQ-030 Send 0x55 with stop bit low, then hold rx low 30 clks, then high -> frame_err pulses once, rx_valid stays 0, busy stays 1 until 2 clks after rx returns high; next frame 0x12 received correctly.
REQ-031 Drive rx low for 3 clks only -> false start, return to IDLE, no rx_valid, no frame_err.
REQ-032 Assert rst for 1 cycle during DATA bit 4 of 0xFF -> all outputs at reset values next cycle; subsequent frame 0x81 received as 0x81.
REQ-033 Hold rx_valid with rx_ready=0, then raise rx_ready in the exact cycle a new byte 0x7E completes -> rx_valid stays 1, rx_byte=0x7E, overrun=0.
